smvm_issue_sched: RTL and testbench
===================================

Name: smvm_issue_sched

Overview:
Issue scheduler in front of the 4-lane Maple ALU in the SMVM datapath. It takes the nonzero stream (value, column index, row-end IPV bit) and packs it into K-lane issue groups, padding the final partial group. Groups go to the ALU under a valid/ready handshake, with a minimum issue interval and an in-flight credit limit. It counts completed rows and signals job completion and format errors.

Parameters:
K, 4, lanes per issue group
VAL_W, 8, matrix value width
COL_W, 9, column index width
ISSUE_GAP, 4, minimum cycles between successive group handshakes (1 = back-to-back)
MAX_INFLIGHT, 2, maximum issued groups not yet returned by the ALU
CNT_W, 16, nonzero counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  job start pulse; sampled only in IDLE
num_nnz  in  CNT_W  nonzeros in job; sampled with start
num_rows  in  9  rows in job; sampled with start
nz_valid  in  1  nonzero entry valid
nz_ready  out  1  scheduler accepts entry
nz_val  in  VAL_W  matrix value
nz_col  in  COL_W  column index
nz_ipv  in  1  1 = entry ends its row
grp_valid  out  1  issue group valid
grp_ready  in  1  ALU accepts group
grp_val  out  K*VAL_W  lane values; lane 0 in MSB slice
grp_col  out  K*COL_W  lane column indices; lane 0 in MSB slice
grp_ipv  out  K  lane IPV bits; lane 0 = bit K-1
grp_last  out  1  group holds the job's final nonzero
ret_valid  in  1  ALU returned one group's result (frees one credit)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
rows_done  out  9  IPV bits issued this job
err  out  1  sticky format error; cleared on next accepted start
perf_stall  out  32  stall counter (see Optional Feature)

Behaviour:
- Clock clk. Reset rst_n: asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, buffers, counters and credits 0. An asserted reset mid-job abandons the job silently.
- States: IDLE, FILL, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches num_nnz and num_rows, clears rows_done/err/lane buffer, and sets busy.
  - num_nnz=0 goes to DONE; otherwise goes to FILL.
  - start outside IDLE is ignored.
- FILL: nz_ready=1. Each handshake writes lane[lane_cnt], increments lane_cnt and nnz_cnt.
  - Go to ISSUE when lane_cnt reaches K, or when nnz_cnt reaches num_nnz (partial group).
  - Unfilled lanes: val=0, col=0, ipv=0.
- ISSUE: nz_ready=0. grp_valid is registered and rises the cycle after the completing nz handshake, when both conditions hold:
  - gap_cnt is 0, where gap_cnt loads ISSUE_GAP-1 on each group handshake and decrements to 0;
  - inflight < MAX_INFLIGHT, or ret_valid=1 in the same cycle.
- Once grp_valid is high, it and all grp_* outputs stay stable until grp_ready.
- On group handshake:
  - inflight increments, unless ret_valid=1 in the same cycle (then unchanged);
  - rows_done += popcount(grp_ipv);
  - lane_cnt clears;
  - next state is DRAIN if grp_last, else FILL.
- ret_valid with inflight=0 sets err; inflight saturates at 0.
- DRAIN: wait for inflight=0, then go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
  - err is set if rows_done != num_rows, or if the final nonzero had nz_ipv=0.
- ISSUE_GAP=1 permits a handshake every cycle. Fill and issue never overlap, so the peak rate is one group per K+1 cycles.

Optional Feature:
SMVM_SCHED_PERF_EN. Defined: perf_stall counts cycles in ISSUE where the group is not handshaken (ALU backpressure, gap or credit). It clears on accepted start and saturates at all-ones. Undefined: perf_stall tied to 0 and the counter logic is absent.

Decomposition:
- Package smvm_pkg: K, VAL_W, COL_W, CNT_W defaults, and the state enum.
- Sub-module smvm_group_packer: lane buffer, lane_cnt, zero padding and packed grp_* outputs.
- The FSM, gap, credit and row counters stay in the top.

Test Plan:
- Job num_nnz=8, num_rows=2, IPV at entries 4 and 8, ISSUE_GAP=4, grp_ready=1, ret_valid 3 cycles after each issue -> two full groups with grp_ipv=4'b0001 each, handshakes ≥4 cycles apart, done once, rows_done=2, err=0.
- num_nnz=5, IPV at entries 2 and 5, num_rows=2 -> second group has lane 0 only, grp_ipv=4'b1000, val/col zero in lanes 1-3, grp_last=1.
- MAX_INFLIGHT=2, ret_valid withheld, 16 nonzeros -> exactly 2 handshakes, grp_valid held stable. One ret_valid then allows the third handshake.
- grp_ready low 10 cycles during ISSUE -> grp_* stable throughout, nz_ready=0; with SMVM_SCHED_PERF_EN, perf_stall=10.
- num_rows=3 but only 2 IPV bits issued, or final nz_ipv=0 -> done pulses and err=1; next start clears err.
- Async reset asserted mid-FILL after 2 entries -> all outputs 0 immediately; new start runs a clean job.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared defaults and FSM state encoding for the SMVM issue scheduler.
package smvm_pkg;
  localparam int K_DEF     = 4;
  localparam int VAL_W_DEF = 8;
  localparam int COL_W_DEF = 9;
  localparam int CNT_W_DEF = 16;
  localparam int ROW_W     = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/smvm_group_packer.sv
// Lane buffer for one issue group: writes land in lane order, unwritten lanes stay zero.
// Outputs are the registered buffer itself, so they hold steady while no write or clear occurs.
module smvm_group_packer
  import smvm_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int VAL_W = VAL_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int LW    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [VAL_W-1:0] wr_val,
  input  logic [COL_W-1:0] wr_col,
  input  logic             wr_ipv,
  output logic [LW-1:0]    lane_cnt,
  output logic [K*VAL_W-1:0] grp_val,
  output logic [K*COL_W-1:0] grp_col,
  output logic [K-1:0]       grp_ipv
);
  logic [VAL_W-1:0] lane_val [K];
  logic [COL_W-1:0] lane_col [K];
  logic             lane_ipv [K];

  // Clearing on every group handshake is what provides zero padding for partial groups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      for (int i = 0; i < K; i++) begin
        lane_val[i] <= '0;
        lane_col[i] <= '0;
        lane_ipv[i] <= 1'b0;
      end
    end else if (clr) begin
      lane_cnt <= '0;
      for (int i = 0; i < K; i++) begin
        lane_val[i] <= '0;
        lane_col[i] <= '0;
        lane_ipv[i] <= 1'b0;
      end
    end else if (wr_en) begin
      lane_cnt <= lane_cnt + LW'(1);
      for (int i = 0; i < K; i++) begin
        if (lane_cnt == LW'(i)) begin
          lane_val[i] <= wr_val;
          lane_col[i] <= wr_col;
          lane_ipv[i] <= wr_ipv;
        end
      end
    end
  end

  // Lane 0 occupies the most significant slice.
  always_comb begin
    grp_val = '0;
    grp_col = '0;
    grp_ipv = '0;
    for (int i = 0; i < K; i++) begin
      grp_val[(K-1-i)*VAL_W +: VAL_W] = lane_val[i];
      grp_col[(K-1-i)*COL_W +: COL_W] = lane_col[i];
      grp_ipv[K-1-i]                  = lane_ipv[i];
    end
  end
endmodule

// File: rtl/smvm_issue_sched.sv
// Packs the nonzero stream into K-lane groups and issues them under gap/credit limits; group valid is registered.
// Optional stall counter behind SMVM_SCHED_PERF_EN; entries are refused while a group waits to issue.
module smvm_issue_sched
  import smvm_pkg::*;
#(
  parameter int K            = K_DEF,
  parameter int VAL_W        = VAL_W_DEF,
  parameter int COL_W        = COL_W_DEF,
  parameter int ISSUE_GAP    = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_nnz,
  input  logic [ROW_W-1:0]   num_rows,
  input  logic               nz_valid,
  output logic               nz_ready,
  input  logic [VAL_W-1:0]   nz_val,
  input  logic [COL_W-1:0]   nz_col,
  input  logic               nz_ipv,
  output logic               grp_valid,
  input  logic               grp_ready,
  output logic [K*VAL_W-1:0] grp_val,
  output logic [K*COL_W-1:0] grp_col,
  output logic [K-1:0]       grp_ipv,
  output logic               grp_last,
  input  logic               ret_valid,
  output logic               busy,
  output logic               done,
  output logic [ROW_W-1:0]   rows_done,
  output logic               err,
  output logic [31:0]        perf_stall
);
  localparam int LW = $clog2(K + 1);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   num_nnz_q, nnz_cnt;
  logic [ROW_W-1:0]   num_rows_q;
  logic [LW-1:0]      lane_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [IW-1:0]      inflight;
  logic               last_ipv;

  logic start_acc, nz_hs, grp_hs, last_nz, fill_done, issue_ok, ret_err, done_err;

  assign start_acc = (state == S_IDLE) && start;
  assign nz_hs     = nz_valid && nz_ready;
  assign grp_hs    = grp_valid && grp_ready;
  assign last_nz   = (nnz_cnt == num_nnz_q - CNT_W'(1));
  assign fill_done = nz_hs && ((lane_cnt == LW'(K - 1)) || last_nz);
  assign issue_ok  = (gap_cnt == '0) && ((inflight < IW'(MAX_INFLIGHT)) || ret_valid);
  assign ret_err   = ret_valid && (inflight == '0);
  assign done_err  = (state == S_DONE) &&
                     ((rows_done != num_rows_q) || ((num_nnz_q != '0) && !last_ipv));

  smvm_group_packer #(.K(K), .VAL_W(VAL_W), .COL_W(COL_W), .LW(LW)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc || grp_hs),
    .wr_en    (nz_hs),
    .wr_val   (nz_val),
    .wr_col   (nz_col),
    .wr_ipv   (nz_ipv),
    .lane_cnt (lane_cnt),
    .grp_val  (grp_val),
    .grp_col  (grp_col),
    .grp_ipv  (grp_ipv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    nz_ready  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nxt = (num_nnz == '0) ? S_DONE : S_FILL;
      S_FILL: begin
        nz_ready = 1'b1;
        if (fill_done) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (grp_hs) state_nxt = grp_last ? S_DRAIN : S_FILL;
      S_DRAIN: if (inflight == '0) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_nnz_q  <= '0;
      num_rows_q <= '0;
      nnz_cnt    <= '0;
      last_ipv   <= 1'b0;
      rows_done  <= '0;
      grp_valid  <= 1'b0;
      grp_last   <= 1'b0;
      gap_cnt    <= '0;
      inflight   <= '0;
      err        <= 1'b0;
    end else begin
      if (start_acc) begin
        num_nnz_q  <= num_nnz;
        num_rows_q <= num_rows;
        nnz_cnt    <= '0;
        last_ipv   <= 1'b0;
      end else if (nz_hs) begin
        nnz_cnt  <= nnz_cnt + CNT_W'(1);
        last_ipv <= nz_ipv;
      end

      if (start_acc)   rows_done <= '0;
      else if (grp_hs) rows_done <= rows_done + ROW_W'($countones(grp_ipv));

      // Valid rises only from FILL completion or while waiting in ISSUE, then holds until accepted.
      if (grp_hs)
        grp_valid <= 1'b0;
      else if ((fill_done || (state == S_ISSUE && !grp_valid)) && issue_ok)
        grp_valid <= 1'b1;

      if (fill_done)   grp_last <= last_nz;
      else if (grp_hs) grp_last <= 1'b0;

      if (grp_hs)              gap_cnt <= GW'(ISSUE_GAP - 1);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);

      if (grp_hs && !ret_valid)                    inflight <= inflight + IW'(1);
      else if (!grp_hs && ret_valid && inflight != '0) inflight <= inflight - IW'(1);

      err <= (start_acc ? 1'b0 : err) | ret_err | done_err;
    end
  end

`ifdef SMVM_SCHED_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_acc)
      stall_q <= '0;
    else if (state == S_ISSUE && !grp_hs && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end
  assign perf_stall = stall_q;
`else
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_smvm_issue_sched.sv
// Directed bench for smvm_issue_sched: linear job sequence with hand-computed group contents.
module tb_smvm_issue_sched;
  logic        clk = 1'b0;
  logic        rst_n, start, nz_valid, nz_ready, nz_ipv;
  logic [15:0] num_nnz;
  logic [8:0]  num_rows, rows_done;
  logic [7:0]  nz_val;
  logic [8:0]  nz_col;
  logic        grp_valid, grp_ready, grp_last, ret_valid, busy, done, err;
  logic [31:0] grp_val, perf_stall;
  logic [35:0] grp_col;
  logic [3:0]  grp_ipv;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int          hs_cyc [$];
  logic [31:0] hs_val [$];
  logic [35:0] hs_col [$];
  logic [3:0]  hs_ipv [$];
  logic        hs_last [$];

  smvm_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_nnz(num_nnz), .num_rows(num_rows),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col), .nz_ipv(nz_ipv),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_val(grp_val), .grp_col(grp_col),
    .grp_ipv(grp_ipv), .grp_last(grp_last), .ret_valid(ret_valid), .busy(busy), .done(done),
    .rows_done(rows_done), .err(err), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && grp_valid && grp_ready) begin
      hs_cyc.push_back(cyc);
      hs_val.push_back(grp_val);
      hs_col.push_back(grp_col);
      hs_ipv.push_back(grp_ipv);
      hs_last.push_back(grp_last);
    end
    if (rst_n && done) done_cnt = done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int n, input int rows);
    num_nnz  = 16'(n);
    num_rows = 9'(rows);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("err_cleared_on_start", err, 1'b0);
  endtask

  // Entry i carries val=i+1, col=i+10.
  task automatic push(input int i, input logic ipv);
    nz_valid = 1'b1;
    nz_val   = 8'(i + 1);
    nz_col   = 9'(i + 10);
    nz_ipv   = ipv;
    for (int t = 0; t < 300 && !nz_ready; t++) tick();
    chk("nz_ready_seen", nz_ready, 1'b1);
    tick();
    nz_valid = 1'b0;
  endtask

  task automatic push_all(input int n, input logic [31:0] mask);
    for (int i = 0; i < n; i++) push(i, mask[i]);
  endtask

  // Returns each group's credit 3 cycles after its handshake.
  task automatic respond(input int base, input int n);
    for (int g = 0; g < n; g++) begin
      for (int t = 0; t < 300 && hs_cyc.size() <= base + g; t++) tick();
      chk("hs_seen", hs_cyc.size() > base + g, 1'b1);
      tick();
      tick();
      ret_valid = 1'b1;
      tick();
      ret_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300 && !done; t++) tick();
    chk("done_pulse", done, 1'b1);
    tick();
  endtask

  task automatic job(input int n, input int rows, input logic [31:0] mask, input int nret);
    int b;
    b = hs_cyc.size();
    start_job(n, rows);
    fork
      push_all(n, mask);
      respond(b, nret);
    join
    wait_done();
  endtask

  initial begin
    int b, d0;
    rst_n = 1'b0; start = 1'b0; num_nnz = '0; num_rows = '0;
    nz_valid = 1'b0; nz_val = '0; nz_col = '0; nz_ipv = 1'b0;
    grp_ready = 1'b1; ret_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_nz_ready", nz_ready, 1'b0);
    chk("rst_grp_valid", grp_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rows_done", rows_done, 9'd0);
    chk("rst_grp_val", grp_val, 32'd0);
    chk("rst_perf", perf_stall, 32'd0);
    rst_n = 1'b1;
    tick();

    // Two full groups, row end in lane 3 of each.
    b = hs_cyc.size(); d0 = done_cnt;
    job(8, 2, 32'h88, 2);
    repeat (3) tick();
    chk("t1_hs_count", hs_cyc.size() - b, 2);
    chk("t1_gap_ge4", (hs_cyc[b+1] - hs_cyc[b]) >= 4, 1'b1);
    chk("t1_ipv0", hs_ipv[b], 4'b0001);
    chk("t1_ipv1", hs_ipv[b+1], 4'b0001);
    chk("t1_val0", hs_val[b], 32'h01020304);
    chk("t1_val1", hs_val[b+1], 32'h05060708);
    chk("t1_col0", hs_col[b], {9'd10, 9'd11, 9'd12, 9'd13});
    chk("t1_col1", hs_col[b+1], {9'd14, 9'd15, 9'd16, 9'd17});
    chk("t1_last0", hs_last[b], 1'b0);
    chk("t1_last1", hs_last[b+1], 1'b1);
    chk("t1_rows_done", rows_done, 9'd2);
    chk("t1_err", err, 1'b0);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_busy_low", busy, 1'b0);

    // Partial final group: lane 0 only, padding zero.
    b = hs_cyc.size();
    job(5, 2, 32'h12, 2);
    tick();
    chk("t2_hs_count", hs_cyc.size() - b, 2);
    chk("t2_ipv0", hs_ipv[b], 4'b0100);
    chk("t2_ipv1", hs_ipv[b+1], 4'b1000);
    chk("t2_val1", hs_val[b+1], 32'h05000000);
    chk("t2_col1", hs_col[b+1], {9'd14, 27'd0});
    chk("t2_last1", hs_last[b+1], 1'b1);
    chk("t2_rows_done", rows_done, 9'd2);
    chk("t2_err", err, 1'b0);

    // Credit limit: third group waits until one credit returns.
    b = hs_cyc.size();
    start_job(16, 4);
    fork
      push_all(16, 32'h8888);
      begin
        for (int t = 0; t < 300 && hs_cyc.size() < b + 2; t++) tick();
        repeat (12) tick();
        chk("t3_two_hs", hs_cyc.size() - b, 2);
        chk("t3_valid_held_low", grp_valid, 1'b0);
        chk("t3_nz_ready_low", nz_ready, 1'b0);
        chk("t3_grp_val_buffered", grp_val, 32'h090A0B0C);
        chk("t3_grp_ipv_buffered", grp_ipv, 4'b0001);
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        chk("t3_valid_after_ret", grp_valid, 1'b1);
        tick();
        chk("t3_third_hs", hs_cyc.size() - b, 3);
        for (int r = 0; r < 3; r++) begin
          repeat (5) tick();
          ret_valid = 1'b1;
          tick();
          ret_valid = 1'b0;
        end
      end
    join
    wait_done();
    tick();
    chk("t3_hs_total", hs_cyc.size() - b, 4);
    chk("t3_rows_done", rows_done, 9'd4);
    chk("t3_err", err, 1'b0);

    // ALU backpressure for 10 cycles in ISSUE.
    b = hs_cyc.size();
    grp_ready = 1'b0;
    start_job(4, 1);
    push_all(4, 32'h8);
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid_hold", grp_valid, 1'b1);
      chk("t4_val_hold", grp_val, 32'h01020304);
      chk("t4_col_hold", grp_col, {9'd10, 9'd11, 9'd12, 9'd13});
      chk("t4_nz_ready_low", nz_ready, 1'b0);
      tick();
    end
    grp_ready = 1'b1;
    tick();
    chk("t4_hs", hs_cyc.size() - b, 1);
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
    wait_done();
`ifdef SMVM_SCHED_PERF_EN
    chk("t4_perf_stall", perf_stall, 32'd10);
`else
    chk("t4_perf_stall", perf_stall, 32'd0);
`endif
    chk("t4_err", err, 1'b0);

    // Row count mismatch, then final entry without row end.
    job(8, 3, 32'h88, 2);
    tick();
    chk("t5_rows_mismatch_err", err, 1'b1);
    chk("t5_rows_done", rows_done, 9'd2);
    job(4, 0, 32'h0, 1);
    tick();
    chk("t5_last_ipv_err", err, 1'b1);
    chk("t5_rows_done_zero", rows_done, 9'd0);

    // Empty job goes straight to DONE.
    start_job(0, 0);
    chk("t0_done", done, 1'b1);
    chk("t0_busy", busy, 1'b1);
    tick();
    chk("t0_busy_low", busy, 1'b0);
    chk("t0_err", err, 1'b0);

    // Asynchronous reset mid-FILL.
    start_job(8, 2);
    push(0, 1'b0);
    push(1, 1'b0);
    chk("t6_partial_fill", grp_val, 32'h01020000);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_nz_ready", nz_ready, 1'b0);
    chk("t6_rst_grp_val", grp_val, 32'd0);
    chk("t6_rst_grp_col", grp_col, 36'd0);
    chk("t6_rst_grp_valid", grp_valid, 1'b0);
    chk("t6_rst_rows_done", rows_done, 9'd0);
    chk("t6_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    b = hs_cyc.size();
    job(8, 2, 32'h88, 2);
    tick();
    chk("t6_hs_count", hs_cyc.size() - b, 2);
    chk("t6_val0", hs_val[b], 32'h01020304);
    chk("t6_rows_done", rows_done, 9'd2);
    chk("t6_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
